// File: rtl/dp_app_ram_ldr_if.sv
// Byte-stream input and RAM init-port output bundle of the DP application RAM loader.
interface dp_app_ram_ldr_if;
    logic [7:0]  BYTE_DAT_IN;
    logic        BYTE_VLD_IN;
    logic        BYTE_RDY_OUT;
    logic        INIT_STR_OUT;
    logic [31:0] INIT_DAT_OUT;
    logic        INIT_VLD_OUT;
    logic        BUSY_OUT;
    logic        DONE_OUT;
    logic [1:0]  ERR_OUT;

    modport slave (
        input  BYTE_DAT_IN, BYTE_VLD_IN,
        output BYTE_RDY_OUT, INIT_STR_OUT, INIT_DAT_OUT, INIT_VLD_OUT,
        output BUSY_OUT, DONE_OUT, ERR_OUT
    );

    modport master (
        output BYTE_DAT_IN, BYTE_VLD_IN,
        input  BYTE_RDY_OUT, INIT_STR_OUT, INIT_DAT_OUT, INIT_VLD_OUT,
        input  BUSY_OUT, DONE_OUT, ERR_OUT
    );
endinterface

// File: rtl/dp_app_ram_ldr.sv
// Boot loader: framed byte stream -> little-endian words on the RAM init port, with length/checksum check.
// Optional inter-byte timeout enabled by defining DP_APP_RAM_LDR_TIMEOUT_EN.
module dp_app_ram_ldr #(
    parameter int unsigned P_ADR     = 10,
    parameter logic [7:0]  P_SYNC    = 8'h50,
    parameter int unsigned P_TIMEOUT = 1024
) (
    input logic              CLK_IN,
    input logic              RST_IN,
    dp_app_ram_ldr_if.slave  ldr
);
    localparam int unsigned LP_WORDS = 32'd1 << (P_ADR - 2);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN0, S_LEN1, S_DAT, S_CHK, S_DONE, S_ERR
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  len_lo_q, len_lo_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  acc_q, acc_d;
    logic [1:0]  lane_q, lane_d;
    logic [23:0] word_q, word_d;
    logic [31:0] dat_q, dat_d;
    logic        str_q, str_d, vld_q, vld_d;
    logic        busy_q, busy_d, done_q, done_d;
    logic [1:0]  err_q, err_d;
    logic        rdy_q;

    logic        acpt_c, sync_c, len_bad_c, chk_ok_c, tmo_hit_c;
    logic [7:0]  byte_c;
    logic [15:0] len_c;

    assign acpt_c    = ldr.BYTE_VLD_IN;
    assign byte_c    = ldr.BYTE_DAT_IN;
    assign sync_c    = (byte_c == P_SYNC);
    assign len_c     = {byte_c, len_lo_q};
    assign len_bad_c = (len_c == 16'd0) || (32'(len_c) > LP_WORDS);
    assign chk_ok_c  = (8'(acc_q + byte_c) == 8'h00);

`ifdef DP_APP_RAM_LDR_TIMEOUT_EN
    localparam int unsigned LP_TW = $clog2(P_TIMEOUT + 1);
    logic [LP_TW-1:0] tmo_q;

    // Idle-cycle counter; only advances while a frame is open and no byte arrives.
    always_ff @(posedge CLK_IN or negedge RST_IN) begin
        if (!RST_IN) begin
            tmo_q <= '0;
        end else if (!busy_q || acpt_c) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + LP_TW'(1);
        end
    end

    assign tmo_hit_c = busy_q && !acpt_c && (tmo_q == LP_TW'(P_TIMEOUT - 1));
`else
    assign tmo_hit_c = (P_TIMEOUT == 0) & 1'b0;
`endif

    // State register
    always_ff @(posedge CLK_IN or negedge RST_IN) begin
        if (!RST_IN) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (tmo_hit_c) begin
            state_d = S_ERR;
        end else if (acpt_c) begin
            case (state_q)
                S_IDLE, S_DONE, S_ERR: if (sync_c) state_d = S_LEN0;
                S_LEN0:                state_d = S_LEN1;
                S_LEN1:                state_d = len_bad_c ? S_ERR : S_DAT;
                S_DAT:                 if (lane_q == 2'd3 && cnt_q == 16'd1) state_d = S_CHK;
                S_CHK:                 state_d = chk_ok_c ? S_DONE : S_ERR;
                default:               state_d = S_IDLE;
            endcase
        end
    end

    // Datapath and registered-output next values
    always_comb begin
        len_lo_d = len_lo_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        lane_d   = lane_q;
        word_d   = word_q;
        dat_d    = dat_q;
        str_d    = 1'b0;
        vld_d    = 1'b0;
        done_d   = done_q;
        err_d    = err_q;
        busy_d   = (state_d == S_LEN0) || (state_d == S_LEN1) ||
                   (state_d == S_DAT)  || (state_d == S_CHK);
        if (tmo_hit_c) begin
            err_d = 2'd3;
        end else if (acpt_c) begin
            case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    if (sync_c) begin
                        done_d = 1'b0;
                        err_d  = 2'd0;
                    end
                end
                S_LEN0: len_lo_d = byte_c;
                S_LEN1: begin
                    if (len_bad_c) begin
                        err_d = 2'd1;
                    end else begin
                        str_d  = 1'b1;
                        cnt_d  = len_c;
                        acc_d  = 8'h00;
                        lane_d = 2'd0;
                    end
                end
                S_DAT: begin
                    acc_d  = 8'(acc_q + byte_c);
                    lane_d = lane_q + 2'd1;
                    // Lanes 0..2 shift down so lane 0 ends up in the low byte.
                    if (lane_q == 2'd3) begin
                        vld_d = 1'b1;
                        dat_d = {byte_c, word_q};
                        cnt_d = cnt_q - 16'd1;
                    end else begin
                        word_d = {byte_c, word_q[23:8]};
                    end
                end
                S_CHK: begin
                    if (chk_ok_c) done_d = 1'b1;
                    else          err_d  = 2'd2;
                end
                default: ;
            endcase
        end
    end

    // Datapath and output registers
    always_ff @(posedge CLK_IN or negedge RST_IN) begin
        if (!RST_IN) begin
            len_lo_q <= 8'h00;
            cnt_q    <= 16'd0;
            acc_q    <= 8'h00;
            lane_q   <= 2'd0;
            word_q   <= 24'd0;
            dat_q    <= 32'd0;
            str_q    <= 1'b0;
            vld_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 2'd0;
            rdy_q    <= 1'b0;
        end else begin
            len_lo_q <= len_lo_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            lane_q   <= lane_d;
            word_q   <= word_d;
            dat_q    <= dat_d;
            str_q    <= str_d;
            vld_q    <= vld_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            rdy_q    <= 1'b1;
        end
    end

    assign ldr.BYTE_RDY_OUT = rdy_q;
    assign ldr.INIT_STR_OUT = str_q;
    assign ldr.INIT_DAT_OUT = dat_q;
    assign ldr.INIT_VLD_OUT = vld_q;
    assign ldr.BUSY_OUT     = busy_q;
    assign ldr.DONE_OUT     = done_q;
    assign ldr.ERR_OUT      = err_q;
endmodule

// File: tb/tb_dp_app_ram_ldr.sv
// Bench for dp_app_ram_ldr: directed vector table, reset/stall sequences and random frames vs a frame-level model.
module tb_dp_app_ram_ldr;
    localparam int         P_ADR = 10;
    localparam int         CAP   = 1 << (P_ADR - 2);
    localparam logic [7:0] SYNC  = 8'h50;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dp_app_ram_ldr_if bus();

    dp_app_ram_ldr #(.P_ADR(P_ADR), .P_SYNC(SYNC), .P_TIMEOUT(16)) dut (
        .CLK_IN(clk), .RST_IN(rst_n), .ldr(bus)
    );

    int          total = 0;
    int          bad   = 0;
    int          mon_str = 0;
    logic [31:0] mon_w[$];
    logic        both_seen = 1'b0;

    int          exp_str;
    logic [31:0] exp_w[$];
    logic        exp_done, exp_busy;
    logic [1:0]  exp_err;
    logic [31:0] exp_dat;

    typedef struct {
        logic [95:0] b;   // bytes left-aligned, first byte in the top octet
        int          n;
        int          str;
        int          nw;
        logic [31:0] w0, w1;
        logic        done;
        logic [1:0]  err;
    } vec_t;
    vec_t vt[5];

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.INIT_STR_OUT) mon_str++;
            if (bus.INIT_VLD_OUT) mon_w.push_back(bus.INIT_DAT_OUT);
            if (bus.INIT_STR_OUT && bus.INIT_VLD_OUT) both_seen = 1'b1;
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, act=running req=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.BYTE_DAT_IN = b;
        bus.BYTE_VLD_IN = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.BYTE_VLD_IN = 1'b0;
        end
    endtask

    task automatic mon_clear();
        mon_str = 0;
        mon_w.delete();
    endtask

    // Frame-level reference: walks the byte list frame by frame using the frame format directly.
    task automatic model_run(input logic [7:0] bs[$]);
        int         i, n, len;
        logic [7:0] s;
        i = 0;
        n = bs.size();
        exp_str = 0;
        exp_w.delete();
        while (i < n) begin
            if (bs[i] != SYNC) begin
                i++;
                continue;
            end
            exp_done = 1'b0;
            exp_err  = 2'd0;
            exp_busy = 1'b1;
            if (i + 2 >= n) return;
            len = int'({bs[i+2], bs[i+1]});
            i += 3;
            if (len == 0 || len > CAP) begin
                exp_err  = 2'd1;
                exp_busy = 1'b0;
                continue;
            end
            exp_str++;
            s = 8'h00;
            for (int w = 0; w < len; w++) begin
                if (i + 4*w + 3 >= n) return;
                exp_dat = {bs[i+4*w+3], bs[i+4*w+2], bs[i+4*w+1], bs[i+4*w]};
                exp_w.push_back(exp_dat);
            end
            for (int k = 0; k < 4*len; k++) s = s + bs[i+k];
            if (i + 4*len >= n) return;
            s = s + bs[i+4*len];
            if (s == 8'h00) exp_done = 1'b1;
            else            exp_err  = 2'd2;
            exp_busy = 1'b0;
            i += 4*len + 1;
        end
    endtask

    task automatic cmp_events(input string tag);
        check({tag, "_str_cnt"}, 32'(mon_str), 32'(exp_str));
        check({tag, "_word_cnt"}, 32'(mon_w.size()), 32'(exp_w.size()));
        for (int k = 0; k < exp_w.size(); k++) begin
            if (k < mon_w.size()) check($sformatf("%s_word%0d", tag, k), mon_w[k], exp_w[k]);
        end
        check({tag, "_done"}, 32'(bus.DONE_OUT), 32'(exp_done));
        check({tag, "_err"},  32'(bus.ERR_OUT),  32'(exp_err));
        check({tag, "_busy"}, 32'(bus.BUSY_OUT), 32'(exp_busy));
        check({tag, "_dat"},  bus.INIT_DAT_OUT,  exp_dat);
        check({tag, "_rdy"},  32'(bus.BYTE_RDY_OUT), 32'd1);
    endtask

    task automatic good_frame_expect();
        exp_str = 1;
        exp_w.delete();
        exp_w.push_back(32'h44332211);
        exp_w.push_back(32'hDDCCBBAA);
        exp_done = 1'b1;
        exp_err  = 2'd0;
        exp_busy = 1'b0;
        exp_dat  = 32'hDDCCBBAA;
    endtask

    task automatic send_vec(input logic [95:0] b, input int n);
        for (int k = 0; k < n; k++) send_byte(b[8*(11-k) +: 8]);
        idle(3);
    endtask

    // Good two-word frame with a gap of 'st' idle cycles after the LEN_H byte.
    task automatic stall_frame(input int st);
        logic [95:0] b;
        b = 96'h5002_0011_2233_44AA_BBCC_DD48;
        mon_clear();
        for (int k = 0; k < 3; k++) send_byte(b[8*(11-k) +: 8]);
        idle(st);
        for (int k = 3; k < 12; k++) send_byte(b[8*(11-k) +: 8]);
        idle(3);
    endtask

    task automatic run_random(input int nfr);
        logic [7:0] fr[$];
        logic [7:0] g, s;
        int         len;
        for (int f = 0; f < nfr; f++) begin
            fr.delete();
            repeat ($urandom_range(0, 3)) begin
                g = 8'($urandom);
                if (g == SYNC) g = 8'h00;
                fr.push_back(g);
            end
            case ($urandom_range(0, 15))
                0:       len = 0;
                1:       len = CAP + 1 + int'($urandom_range(0, 2000));
                2:       len = CAP;
                default: len = int'($urandom_range(1, 8));
            endcase
            if (f == 0) len = CAP;
            fr.push_back(SYNC);
            fr.push_back(8'(len));
            fr.push_back(8'(len >> 8));
            if (len > 0 && len <= CAP) begin
                s = 8'h00;
                for (int k = 0; k < 4*len; k++) begin
                    g = 8'($urandom);
                    s = s + g;
                    fr.push_back(g);
                end
                g = 8'(8'h00 - s);
                if ($urandom_range(0, 3) == 0) g = g + 8'($urandom_range(1, 255));
                fr.push_back(g);
            end
            model_run(fr);
            mon_clear();
            foreach (fr[k]) begin
                if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
                send_byte(fr[k]);
            end
            idle(3);
            cmp_events($sformatf("rnd%0d", f));
        end
    endtask

    initial begin
        vt[0] = '{96'h5002_0011_2233_44AA_BBCC_DD48, 12, 1, 2, 32'h44332211, 32'hDDCCBBAA, 1'b1, 2'd0};
        vt[1] = '{{40'h00FF500000, 56'h0},          5, 0, 0, 32'h0,        32'h0,        1'b0, 2'd1};
        vt[2] = '{96'h5002_0011_2233_44AA_BBCC_DD48, 12, 1, 2, 32'h44332211, 32'hDDCCBBAA, 1'b1, 2'd0};
        vt[3] = '{{24'h500101, 72'h0},              3, 0, 0, 32'h0,        32'h0,        1'b0, 2'd1};
        vt[4] = '{96'h5002_0011_2233_44AA_BBCC_DD49, 12, 1, 2, 32'h44332211, 32'hDDCCBBAA, 1'b0, 2'd2};

        bus.BYTE_DAT_IN = 8'h00;
        bus.BYTE_VLD_IN = 1'b0;
        #1;
        check("rst_rdy_low", 32'(bus.BYTE_RDY_OUT), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_rdy", 32'(bus.BYTE_RDY_OUT), 32'd1);
        check("rst_outs", {bus.INIT_STR_OUT, bus.INIT_VLD_OUT, bus.BUSY_OUT, bus.DONE_OUT, bus.ERR_OUT}, 32'd0);
        check("rst_dat", bus.INIT_DAT_OUT, 32'd0);

        exp_dat = 32'h0;
        foreach (vt[i]) begin
            mon_clear();
            send_vec(vt[i].b, vt[i].n);
            exp_str = vt[i].str;
            exp_w.delete();
            if (vt[i].nw > 0) exp_w.push_back(vt[i].w0);
            if (vt[i].nw > 1) exp_w.push_back(vt[i].w1);
            if (vt[i].nw > 0) exp_dat = vt[i].w1;
            exp_done = vt[i].done;
            exp_err  = vt[i].err;
            exp_busy = 1'b0;
            cmp_events($sformatf("vec%0d", i));
        end

        // Reset in the middle of a frame, then a full good frame.
        mon_clear();
        send_vec(96'h5002_0011_2233_0000_0000_0000, 6);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_rdy", 32'(bus.BYTE_RDY_OUT), 32'd0);
        check("midrst_outs", {bus.INIT_STR_OUT, bus.INIT_VLD_OUT, bus.BUSY_OUT, bus.DONE_OUT, bus.ERR_OUT}, 32'd0);
        check("midrst_dat", bus.INIT_DAT_OUT, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_rdy_rel", 32'(bus.BYTE_RDY_OUT), 32'd1);
        mon_clear();
        send_vec(96'h5002_0011_2233_44AA_BBCC_DD48, 12);
        good_frame_expect();
        cmp_events("after_rst");

        run_random(30);

`ifdef DP_APP_RAM_LDR_TIMEOUT_EN
        stall_frame(16);
        exp_str = 1;
        exp_w.delete();
        exp_done = 1'b0;
        exp_err  = 2'd3;
        exp_busy = 1'b0;
        cmp_events("tmo16");
        stall_frame(15);
        good_frame_expect();
        cmp_events("tmo15");
`else
        stall_frame(16);
        good_frame_expect();
        cmp_events("stall16");
        stall_frame(60);
        good_frame_expect();
        cmp_events("stall60");
`endif

        check("str_vld_exclusive", 32'(both_seen), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dp_app_ram_ldr.md
# dp_app_ram_ldr

Byte-stream loader that fills the DP application RAM at boot. It receives a framed byte stream, for example from a host UART or an SPI flash reader. It assembles little-endian 32-bit words and drives the RAM initialization port (start / data / valid), which is the writer side of that port. It validates the frame length and checksum, and reports done or error so the application CPU is released only after a good image.

## Interface
Parameters:
- P_ADR, 10: byte address bits of the target RAM. Word capacity is 2**(P_ADR-2).
- P_SYNC, 8'h50: frame sync byte.
- P_TIMEOUT, 1024: inter-byte timeout in clock cycles. Used only with the timeout macro.

Ports:
- CLK_IN  input  1: clock.
- RST_IN  input  1: reset, asynchronous, active-low.
- BYTE_DAT_IN  input  8: stream byte.
- BYTE_VLD_IN  input  1: stream byte valid.
- BYTE_RDY_OUT  output  1: ready. Constant 1 after reset; the loader never back-pressures.
- INIT_STR_OUT  output  1: one-cycle pulse that clears the RAM write pointer.
- INIT_DAT_OUT  output  32: assembled word.
- INIT_VLD_OUT  output  1: one-cycle word write strobe.
- BUSY_OUT  output  1: frame in progress.
- DONE_OUT  output  1: last frame loaded with a good checksum.
- ERR_OUT  output  2: error code.
  - 0: none.
  - 1: length invalid.
  - 2: checksum mismatch.
  - 3: timeout.

## Operation
Frame format:
- Sync byte.
- LEN_L, LEN_H: word count, 16 bits, little-endian.
- LEN×4 data bytes, each word least-significant byte first.
- CHK byte: chosen so that the 8-bit sum of all data bytes plus CHK equals 0.

A byte is accepted when BYTE_VLD_IN = 1 (BYTE_RDY_OUT is always 1).

State machine:
- IDLE: non-sync bytes are ignored. Sync → LEN0; set BUSY, clear DONE and ERR.
- LEN0: capture LEN_L → LEN1.
- LEN1: capture LEN_H.
  - LEN = 0 or LEN > 2**(P_ADR-2) → ERR state, ERR_OUT=1, no INIT_STR.
  - Otherwise pulse INIT_STR, load the word counter with LEN, clear the checksum accumulator, clear the byte lane counter → DAT.
- DAT: shift bytes into lanes 0..3 and add each byte to the 8-bit accumulator.
  - On lane 3, pulse INIT_VLD with the completed word and decrement the word counter.
  - Counter reaching 0 → CHK.
- CHK: accumulator + byte.
  - Equal to 0 → DONE state, DONE_OUT=1.
  - Otherwise → ERR state, ERR_OUT=2.
- DONE / ERR: outputs held. A sync byte restarts the frame exactly as from IDLE. Any other byte is ignored.

Further rules:
- Data words are already written to RAM when a checksum error is detected. Downstream logic must gate the CPU on DONE_OUT.
- BUSY_OUT = 1 in LEN0, LEN1, DAT and CHK; 0 otherwise.
- Word counter is 16 bits; byte lane counter is 2 bits and wraps.
- INIT_STR_OUT and INIT_VLD_OUT are never asserted in the same cycle.

## Timing
- Reset values:
  - BYTE_RDY_OUT=0 while RST_IN is low, then 1.
  - INIT_STR_OUT=0, INIT_VLD_OUT=0, INIT_DAT_OUT=0.
  - BUSY_OUT=0, DONE_OUT=0, ERR_OUT=0.
  - State IDLE.
- All outputs are registered.
- INIT_STR_OUT is high in the cycle after the LEN_H byte is accepted.
- INIT_VLD_OUT and INIT_DAT_OUT are valid in the cycle after the 4th byte of a word is accepted. INIT_DAT_OUT holds until the next word.
- DONE_OUT or ERR_OUT updates in the cycle after the CHK byte (or LEN_H, for a length error) is accepted.
- Back-to-back bytes every cycle are supported with no bubbles.
- Reset asserted mid-frame aborts immediately to reset values. RAM contents are untouched beyond words already strobed.

## Configuration
- DP_APP_RAM_LDR_TIMEOUT_EN defined:
  - A counter runs while BUSY_OUT=1 and is cleared on every accepted byte.
  - Reaching P_TIMEOUT cycles without a byte → ERR state, ERR_OUT=3, BUSY_OUT=0.
- Not defined: no counter. The loader waits indefinitely and ERR_OUT never equals 3.

## Test plan
- Good frame, P_ADR=10:
  - Stimulus: bytes 50 02 00 11 22 33 44 AA BB CC DD 48.
  - Response: one INIT_STR; INIT_VLD with 0x44332211 then 0xDDCCBBAA; DONE_OUT=1, ERR_OUT=0, BUSY_OUT=0.
- Garbage then length 0:
  - Stimulus: bytes 00 FF 50 00 00.
  - Response: garbage ignored; no INIT_STR; ERR_OUT=1.
  - Then a good frame clears ERR_OUT.
- Oversize:
  - Stimulus: LEN=0x0101 (257) with P_ADR=10.
  - Response: ERR_OUT=1; no INIT_STR or INIT_VLD.
- Bad checksum:
  - Stimulus: same frame as the first scenario with CHK=0x49.
  - Response: both INIT_VLD strobes still occur; ERR_OUT=2; DONE_OUT=0.
- Reset mid-frame:
  - Stimulus: RST_IN low after the 6th byte.
  - Response: all outputs at reset values.
  - A full good frame afterwards loads correctly.
- Timeout, macro defined, P_TIMEOUT=16:
  - Stimulus: stall 16 cycles after the 3rd byte.
  - Response: ERR_OUT=3 and BUSY_OUT=0.
  - A 15-cycle stall does not trip the timeout.
